// File: rtl/matrix_mult_pkg.sv
// Shared constants, state encoding and address helper for the 4x4 matrix
// multiplier sequencer.
package matrix_mult_pkg;

    localparam int DIM    = 4;
    localparam int IDX_W  = 2;
    localparam int ADDR_W = 4;

    localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Row-major element index; DIM is a power of two so the index is {row, col}.
    function automatic logic [ADDR_W-1:0] row_major(
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/matrix_mult_sequencer_mac_unit.sv
// Registered multiply-accumulate for one dot product: load starts a new sum,
// otherwise the product is added to the running total.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] ext_a_s;
    logic [ACC_W-1:0] ext_b_s;
    logic [ACC_W-1:0] prod_s;
    logic [ACC_W-1:0] acc_r;

    // Operand extension and product; modulo-2^ACC_W arithmetic keeps signed results exact.
    always_comb begin
        ext_a_s = {{(ACC_W-DATA_W){1'b0}}, a};
        ext_b_s = {{(ACC_W-DATA_W){1'b0}}, b};
        if (signed_mode) begin
            ext_a_s = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
            ext_b_s = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
        end else begin
            ext_a_s = {{(ACC_W-DATA_W){1'b0}}, a};
            ext_b_s = {{(ACC_W-DATA_W){1'b0}}, b};
        end
        prod_s = ext_a_s * ext_b_s;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= load ? prod_s : (acc_r + prod_s);
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Sequencer for C = A x B on 4x4 matrices: issues operand reads, drives the
// MAC and writes each result over a ready/valid port.
module matrix_mult_sequencer
    import matrix_mult_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic [3:0]        a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    output logic              b_rd_en,
    output logic [3:0]        b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              c_wr_en,
    output logic [3:0]        c_wr_addr,
    output logic [ACC_W-1:0]  c_wr_data,
    input  logic              c_wr_ready
);

    seq_state_t        state_r;
    seq_state_t        fsm_n_s;
    seq_state_t        state_n_s;
    logic [IDX_W-1:0]  i_r, j_r, k_r;
    logic [IDX_W-1:0]  i_n_s, j_n_s, k_n_s;
    logic              signed_mode_r;
    logic              signed_n_s;
    logic              abort_s;
    logic              fetch_n_s;
    logic              write_n_s;

    logic              busy_r;
    logic              done_r;
    logic              a_rd_en_r;
    logic              b_rd_en_r;
    logic [ADDR_W-1:0] a_rd_addr_r;
    logic [ADDR_W-1:0] b_rd_addr_r;
    logic              c_wr_en_r;
    logic [ADDR_W-1:0] c_wr_addr_r;

    logic              mac_en_r;
    logic              mac_load_r;
    logic [ACC_W-1:0]  acc_s;

    // Next-state and counter logic for the fetch/drain/write sequence.
    always_comb begin
        fsm_n_s    = state_r;
        i_n_s      = i_r;
        j_n_s      = j_r;
        k_n_s      = k_r;
        signed_n_s = signed_mode_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    fsm_n_s    = ST_FETCH;
                    i_n_s      = IDX_ZERO;
                    j_n_s      = IDX_ZERO;
                    k_n_s      = IDX_ZERO;
                    signed_n_s = signed_mode;
                end else begin
                    fsm_n_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                k_n_s = k_r + IDX_ONE;
                if (k_r == LAST_IDX) begin
                    fsm_n_s = ST_DRAIN;
                end else begin
                    fsm_n_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                fsm_n_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (c_wr_ready) begin
                    k_n_s = IDX_ZERO;
                    j_n_s = j_r + IDX_ONE;
                    if (j_r == LAST_IDX) begin
                        i_n_s = i_r + IDX_ONE;
                    end else begin
                        i_n_s = i_r;
                    end
                    if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) begin
                        fsm_n_s = ST_DONE;
                    end else begin
                        fsm_n_s = ST_FETCH;
                    end
                end else begin
                    fsm_n_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                fsm_n_s = ST_IDLE;
            end
            default: begin
                fsm_n_s = ST_IDLE;
            end
        endcase
    end

    // Abort outranks everything, including a write accepted in the same cycle.
    assign abort_s   = abort && (state_r != ST_IDLE);
    assign state_n_s = abort_s ? ST_IDLE : fsm_n_s;
    assign fetch_n_s = (state_n_s == ST_FETCH);
    assign write_n_s = (state_n_s == ST_WRITE);

    // State, loop counters and latched operand mode.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r       <= ST_IDLE;
            i_r           <= IDX_ZERO;
            j_r           <= IDX_ZERO;
            k_r           <= IDX_ZERO;
            signed_mode_r <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            i_r           <= i_n_s;
            j_r           <= j_n_s;
            k_r           <= k_n_s;
            signed_mode_r <= signed_n_s;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            a_rd_en_r   <= 1'b0;
            b_rd_en_r   <= 1'b0;
            a_rd_addr_r <= ADDR_ZERO;
            b_rd_addr_r <= ADDR_ZERO;
            c_wr_en_r   <= 1'b0;
            c_wr_addr_r <= ADDR_ZERO;
        end else begin
            busy_r      <= (state_n_s != ST_IDLE);
            done_r      <= (state_n_s == ST_DONE);
            a_rd_en_r   <= fetch_n_s;
            b_rd_en_r   <= fetch_n_s;
            a_rd_addr_r <= fetch_n_s ? row_major(i_n_s, k_n_s) : ADDR_ZERO;
            b_rd_addr_r <= fetch_n_s ? row_major(k_n_s, j_n_s) : ADDR_ZERO;
            c_wr_en_r   <= write_n_s;
            c_wr_addr_r <= write_n_s ? row_major(i_n_s, j_n_s) : ADDR_ZERO;
        end
    end

    // Read data returns one cycle after the strobe, so MAC control lags the read by one cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mac_en_r   <= 1'b0;
            mac_load_r <= 1'b0;
        end else begin
            mac_en_r   <= a_rd_en_r && !abort_s;
            mac_load_r <= a_rd_en_r && (k_r == IDX_ZERO);
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (ACLK),
        .rst         (ARESET),
        .en          (mac_en_r),
        .load        (mac_load_r),
        .signed_mode (signed_mode_r),
        .a           (a_rd_data),
        .b           (b_rd_data),
        .acc         (acc_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign a_rd_en   = a_rd_en_r;
    assign b_rd_en   = b_rd_en_r;
    assign a_rd_addr = a_rd_addr_r;
    assign b_rd_addr = b_rd_addr_r;
    assign c_wr_en   = c_wr_en_r;
    assign c_wr_addr = c_wr_addr_r;
    // The accumulator is held through WRITE, so it serves directly as the write data register.
    assign c_wr_data = acc_s;

endmodule
